spi_usb_periph_responder: RTL

//  SPI peripheral (responder) end of the spi0 link driven by the SoC SPI master. Emulates a
//  MAX3421E-style register file: 32x8 regs, command byte = {reg[4:0],0,dir,ackstat}.

---
 rtl/spi_usb_periph_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_usb_periph_responder.sv
// SPI mode-0 responder emulating a MAX3421E-style 32x8 register file, with a host
// port for preload/inspection and interrupt injection.
module spi_usb_periph_responder #(
  parameter int NREG      = 32,
  parameter int HIRQ_ADDR = 25,
  parameter int HIEN_ADDR = 26,
  parameter int SYNC_STG  = 2
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic                    spi_SCLK,
  input  logic                    spi_MOSI,
  input  logic                    spi_SS_n,
  output logic                    spi_MISO,
  output logic                    spi_MISO_oe,
  input  logic [$clog2(NREG)-1:0] hp_addr,
  input  logic [7:0]              hp_wdata,
  input  logic                    hp_we,
  output logic [7:0]              hp_rdata,
  input  logic [7:0]              hp_irq_set,
  output logic                    irq_n,
  output logic                    byte_done,
  output logic [7:0]              cmd_byte
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t              r_state;
  logic [SYNC_STG-1:0] r_sclk_s, r_mosi_s, r_ss_s;
  logic                r_sclk_d, r_ss_d;
  logic [7:0]          r_regs [NREG];
  logic [6:0]          r_rx;
  logic [7:0]          r_tx;
  logic [2:0]          r_bitcnt;
  logic                r_load, r_dir, r_oe, r_byte_done, r_irq_n;
  logic [AW-1:0]       r_addr;
  logic [7:0]          r_cmd, r_hp_rdata;

  logic       w_sclk, w_mosi, w_ss, w_rise, w_fall, w_ss_fall, w_last, w_spi_wr;
  logic [7:0] w_byte, w_hirq_nxt;

  assign w_sclk    = r_sclk_s[SYNC_STG-1];
  assign w_mosi    = r_mosi_s[SYNC_STG-1];
  assign w_ss      = r_ss_s[SYNC_STG-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_ss_fall = r_ss_d & ~w_ss;
  assign w_byte    = {r_rx, w_mosi};
  assign w_last    = w_rise && (r_bitcnt == 3'd7) && !w_ss && (r_state != S_IDLE);
  assign w_spi_wr  = w_last && (r_state == S_DATA) && r_dir;

  assign spi_MISO    = r_tx[7];
  assign spi_MISO_oe = r_oe;
  assign hp_rdata    = r_hp_rdata;
  assign irq_n       = r_irq_n;
  assign byte_done   = r_byte_done;
  assign cmd_byte    = r_cmd;

  // HIRQ: SPI W1C beats a host write; injected bits land after the clear.
  always_comb begin
    w_hirq_nxt = r_regs[HIRQ_ADDR];
    if (hp_we && hp_addr == AW'(HIRQ_ADDR)) w_hirq_nxt = hp_wdata;
    if (w_spi_wr && r_addr == AW'(HIRQ_ADDR)) w_hirq_nxt = r_regs[HIRQ_ADDR] & ~w_byte;
    w_hirq_nxt = w_hirq_nxt | hp_irq_set;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (hp_we)    r_regs[hp_addr] <= hp_wdata;
      if (w_spi_wr) r_regs[r_addr]  <= w_byte;
      r_regs[HIRQ_ADDR] <= w_hirq_nxt;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_hp_rdata <= '0;
      r_irq_n    <= 1'b1;
    end else begin
      r_hp_rdata <= r_regs[hp_addr];
      r_irq_n    <= ~|(r_regs[HIRQ_ADDR] & r_regs[HIEN_ADDR]);
    end
  end

  // SS sync resets to "low" so a select already low at reset release never
  // produces a falling edge; a transfer starts only after SS_n is seen high.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sclk_s    <= '0;
      r_mosi_s    <= '0;
      r_ss_s      <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b0;
      r_state     <= S_IDLE;
      r_rx        <= '0;
      r_tx        <= '0;
      r_bitcnt    <= '0;
      r_load      <= 1'b0;
      r_dir       <= 1'b0;
      r_addr      <= '0;
      r_oe        <= 1'b0;
      r_byte_done <= 1'b0;
      r_cmd       <= '0;
    end else begin
      r_sclk_s    <= {r_sclk_s[SYNC_STG-2:0], spi_SCLK};
      r_mosi_s    <= {r_mosi_s[SYNC_STG-2:0], spi_MOSI};
      r_ss_s      <= {r_ss_s[SYNC_STG-2:0], spi_SS_n};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
      r_byte_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ss_fall) begin
            r_state  <= S_CMD;
            r_bitcnt <= '0;
            r_load   <= 1'b0;
            r_tx     <= r_regs[HIRQ_ADDR];
            r_oe     <= 1'b1;
          end
        end
        default: begin
          if (w_ss) begin
            r_state  <= S_IDLE;
            r_tx     <= '0;
            r_oe     <= 1'b0;
            r_bitcnt <= '0;
            r_load   <= 1'b0;
          end else if (w_rise) begin
            r_rx     <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              r_byte_done <= 1'b1;
              r_load      <= 1'b1;
              if (r_state == S_CMD) begin
                r_cmd   <= w_byte;
                r_addr  <= w_byte[7:3];
                r_dir   <= w_byte[1];
                r_state <= S_DATA;
              end
            end
          end else if (w_fall) begin
            // First fall after a completed byte loads the next outgoing byte.
            if (r_load) begin
              r_load <= 1'b0;
              r_tx   <= r_dir ? 8'h00 : r_regs[r_addr];
            end else begin
              r_tx <= {r_tx[6:0], 1'b0};
            end
          end
        end
      endcase
    end
  end
endmodule
